// File: rtl/uart_tx_ser.sv
// UART 8N1/8N2 serializer: accepts a byte on a one-cycle request, shifts it out
// LSB first with one start bit and STOP_BITS stop bits. All outputs are registered.
module uart_tx_ser #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1          // 1 or 2
) (
  input  logic       clk,
  input  logic       ic_rst_n,
  input  logic [7:0] id_txdw,
  input  logic       ic_txena,
  output logic       oc_txbusy,
  output logic       od_tx
);

  localparam int DIV = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic          r_stop,  w_stop_nxt;
  logic [7:0]    r_sh,    w_sh_nxt;
  logic          r_tx,    w_tx_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == CNT_MAX);
  assign od_tx     = r_tx;
  assign oc_txbusy = r_busy;

  // od_tx/oc_txbusy are computed for the next state so they toggle on the
  // same edge as the state change rather than a cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop;
    w_sh_nxt    = r_sh;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (ic_txena && !r_busy) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
          w_stop_nxt  = 1'b0;
          w_sh_nxt    = id_txdw;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_tx_nxt    = r_sh[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          w_sh_nxt  = {1'b0, r_sh[7:1]};
          w_idx_nxt = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_stop_nxt  = 1'b0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt = r_sh[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_stop == STOP_LAST) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_stop  <= 1'b0;
      r_sh    <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_stop  <= w_stop_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: cycle-exact waveform checks plus a line-decoding
// monitor that pops expected bytes from a scoreboard queue.
module tb_uart_tx_ser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data1, data2;
  logic       txena1, txena2;
  logic       busy1, busy2, tx1, tx2;

  always #5 clk = ~clk;

  uart_tx_ser #(.CLK_FREQ(100), .BAUD(10), .STOP_BITS(1)) u1 (
    .clk(clk), .ic_rst_n(rst_n), .id_txdw(data1), .ic_txena(txena1),
    .oc_txbusy(busy1), .od_tx(tx1));

  uart_tx_ser #(.CLK_FREQ(100), .BAUD(10), .STOP_BITS(2)) u2 (
    .clk(clk), .ic_rst_n(rst_n), .id_txdw(data2), .ic_txena(txena2),
    .oc_txbusy(busy2), .od_tx(tx2));

  int n_vec = 0;
  int n_err = 0;
  int n_exp = 0;
  int rx_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Line monitor for u1: mid-bit sampling, 10 clocks per bit.
  bit         m_act = 1'b0;
  int         m_cnt;
  logic [7:0] m_byte;
  logic [7:0] m_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx1 == 1'b0) begin
        m_act  = 1'b1;
        m_cnt  = 0;
        m_byte = 8'h00;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= 15 && m_cnt <= 85 && (m_cnt % 10) == 5)
        m_byte[(m_cnt-15)/10] = tx1;
      if (m_cnt == 95) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx unexpected frame: got %02h want none", m_byte);
        end else begin
          m_exp = exp_q.pop_front();
          chk("rx byte", m_byte, m_exp);
        end
        chk("rx stop", tx1, 1);
        m_act = 1'b0;
      end
    end
  end

  task automatic idle_now();
    chk("idle tx1", tx1, 1);
    chk("idle busy1", busy1, 0);
    chk("idle tx2", tx2, 1);
    chk("idle busy2", busy2, 0);
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      idle_now();
      @(negedge clk);
    end
  endtask

  task automatic start_req(input int which, input logic [7:0] b);
    if (which == 1) begin
      data1 = b; txena1 = 1'b1;
      exp_q.push_back(b);
      n_exp++;
    end else begin
      data2 = b; txena2 = 1'b1;
    end
    @(negedge clk);
    txena1 = 1'b0;
    txena2 = 1'b0;
  endtask

  // Checks ncyc cycles of a frame from the first start-bit cycle on.
  task automatic check_wave(input int which, input logic [7:0] b, input int ign_at, input int ncyc);
    logic e;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 10)      e = 1'b0;
      else if (c < 90) e = b[(c-10)/10];
      else             e = 1'b1;
      chk($sformatf("u%0d f%02h c%0d tx", which, b, c), (which == 1) ? tx1 : tx2, e);
      chk($sformatf("u%0d f%02h c%0d busy", which, b, c), (which == 1) ? busy1 : busy2, 1);
      if (ign_at >= 0 && c == ign_at) begin
        if (which == 1) begin txena1 = 1'b1; data1 = 8'hFF; end
        else            begin txena2 = 1'b1; data2 = 8'hFF; end
      end else begin
        txena1 = 1'b0;
        txena2 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         ign_at;
    bit         b2b;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, -1, 1'b0};
    tbl[1] = '{8'hA5, 35, 1'b0};
    tbl[2] = '{8'h01, -1, 1'b0};
    tbl[3] = '{8'h80, -1, 1'b1};
    tbl[4] = '{8'hFF, -1, 1'b0};
    tbl[5] = '{8'h55, -1, 1'b1};
    tbl[6] = '{8'h00, -1, 1'b0};

    rst_n = 1'b0; data1 = 8'h00; data2 = 8'h00; txena1 = 1'b0; txena2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_now();
    end
    rst_n = 1'b1;
    idle_chk(5);

    for (int i = 0; i < 7; i++) begin
      if (!tbl[i].b2b) idle_chk(3);
      idle_now();
      start_req(1, tbl[i].data);
      check_wave(1, tbl[i].data, tbl[i].ign_at, 100);
    end
    idle_chk(3);

    // Reset during data bit 3 of 0x3C, then resend it.
    start_req(1, 8'h3C);
    check_wave(1, 8'h3C, -1, 45);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    n_exp--;
    #1;
    chk("async rst tx1", tx1, 1);
    chk("async rst busy1", busy1, 0);
    @(negedge clk);
    idle_now();
    @(negedge clk);
    idle_now();
    rst_n = 1'b1;
    idle_chk(3);
    start_req(1, 8'h3C);
    check_wave(1, 8'h3C, -1, 100);
    idle_chk(3);

    // Two stop bits: 90 clocks low, 20 high, busy for 110.
    start_req(2, 8'h00);
    check_wave(2, 8'h00, -1, 110);
    idle_chk(3);

    chk("frame count", rx_cnt, n_exp);
    chk("queue empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
